// File: rtl/gpio_pkg.sv
// gpio_pkg: shared widths, register map, op-codes and master FSM states for the GPIO register bus
package gpio_pkg;
   localparam int REG_WIDTH = 32;
   localparam logic [31:0] DDR_ADDR  = 32'd128;
   localparam logic [31:0] PIN_ADDR  = 32'd129;
   localparam logic [31:0] PORT_ADDR = 32'd130;
   typedef enum logic [2:0] {
      OP_READ  = 3'd0,
      OP_WRITE = 3'd1,
      OP_SET   = 3'd2,
      OP_CLR   = 3'd3,
      OP_TGL   = 3'd4
   } op_e;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_e;
endpackage

// File: rtl/gpio_rmw_alu.sv
// gpio_rmw_alu: new register value for SET/CLR/TGL from the value just read and the command mask
module gpio_rmw_alu #(
   parameter int REG_WIDTH = gpio_pkg::REG_WIDTH
) (
   input  logic [2:0]           op,
   input  logic [REG_WIDTH-1:0] old_val,
   input  logic [REG_WIDTH-1:0] mask,
   output logic [REG_WIDTH-1:0] new_val
);
   import gpio_pkg::*;
   always_comb begin
      new_val = op == OP_SET ? (old_val | mask) :
                op == OP_CLR ? (old_val & ~mask) :
                op == OP_TGL ? (old_val ^ mask) : mask;
   end
endmodule

// File: rtl/gpio_bus_master.sv
// gpio_bus_master: turns valid/ready GPIO commands into single-beat register reads, writes and
// atomic read-modify-writes, returning exactly one response per command
module gpio_bus_master #(
   parameter int                                 REG_WIDTH = gpio_pkg::REG_WIDTH,
   parameter logic [gpio_pkg::REG_WIDTH-1:0]     DDR_ADDR  = gpio_pkg::DDR_ADDR,
   parameter logic [gpio_pkg::REG_WIDTH-1:0]     PIN_ADDR  = gpio_pkg::PIN_ADDR,
   parameter logic [gpio_pkg::REG_WIDTH-1:0]     PORT_ADDR = gpio_pkg::PORT_ADDR,
   parameter int                                 READ_WAIT = 0
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [REG_WIDTH-1:0] cmd_addr,
   input  logic [REG_WIDTH-1:0] cmd_data,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [REG_WIDTH-1:0] rsp_data,
   output logic                 rsp_err,
   output logic [REG_WIDTH-1:0] gpio_addr,
   output logic [REG_WIDTH-1:0] gpio_i_data,
   output logic                 we,
   input  logic [REG_WIDTH-1:0] gpio_o_data
);
   import gpio_pkg::*;
   state_e               state;
   logic [2:0]           op;
   logic [REG_WIDTH-1:0] mask;
   logic [2:0]           cnt;
   logic [REG_WIDTH-1:0] rmw_val;
   logic                 mapped;
   logic                 legal;
   // PIN is read-only, so any write or RMW aimed at it is rejected before touching the bus
   assign mapped = cmd_addr == DDR_ADDR || cmd_addr == PIN_ADDR || cmd_addr == PORT_ADDR;
   assign legal  = cmd_op <= OP_TGL && mapped && !(cmd_addr == PIN_ADDR && cmd_op != OP_READ);
   gpio_rmw_alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
      .op      (op),
      .old_val (gpio_o_data),
      .mask    (mask),
      .new_val (rmw_val)
   );
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= S_IDLE;
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_data    <= '0;
         gpio_addr   <= '0;
         gpio_i_data <= '0;
         we          <= 1'b0;
         op          <= '0;
         mask        <= '0;
         cnt         <= '0;
      end else begin
         case (state)
            S_IDLE: if (cmd_valid) begin
               cmd_ready <= 1'b0;
               op        <= cmd_op;
               mask      <= cmd_data;
               cnt       <= 3'(READ_WAIT);
               if (!legal) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= '0;
               end else if (cmd_op == OP_WRITE) begin
                  state       <= S_WR;
                  gpio_addr   <= cmd_addr;
                  gpio_i_data <= cmd_data;
                  we          <= 1'b1;
               end else begin
                  state     <= S_RD;
                  gpio_addr <= cmd_addr;
               end
            end
            // address is held for READ_WAIT extra cycles so the pins settle before sampling
            S_RD: if (cnt != 3'd0) begin
               cnt <= cnt - 3'd1;
            end else if (op == OP_READ) begin
               state     <= S_RESP;
               rsp_valid <= 1'b1;
               rsp_data  <= gpio_o_data;
               gpio_addr <= '0;
            end else begin
               state       <= S_WR;
               gpio_i_data <= rmw_val;
               we          <= 1'b1;
            end
            S_WR: begin
               state       <= S_RESP;
               rsp_valid   <= 1'b1;
               rsp_data    <= gpio_i_data;
               we          <= 1'b0;
               gpio_addr   <= '0;
               gpio_i_data <= '0;
            end
            S_RESP: if (rsp_ready) begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_data  <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gpio_bus_master.sv
// tb_gpio_bus_master: two masters (READ_WAIT 0 and 3) each paired with a small gpio peripheral,
// checked against a register-level model of DDR/PORT/PIN
module tb_gpio_bus_master;
   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        cmd_valid[2];
   logic        rsp_ready[2];
   logic [2:0]  cmd_op[2];
   logic [31:0] cmd_addr[2];
   logic [31:0] cmd_data[2];
   logic        cmd_ready_w[2];
   logic        rsp_valid_w[2];
   logic        rsp_err_w[2];
   logic        we_w[2];
   logic [31:0] rsp_data_w[2];
   logic [31:0] gaddr[2];
   logic [31:0] gwdata[2];
   logic [31:0] grdata[2];
   logic [31:0] p_ddr[2]  = '{default: '0};
   logic [31:0] p_port[2] = '{default: '0};
   logic [31:0] io = '0;
   logic [31:0] m_ddr[2]  = '{default: '0};
   logic [31:0] m_port[2] = '{default: '0};
   logic [32:0] q0[$];
   logic [32:0] q1[$];
   logic [32:0] cmp_e;
   int          cmp_n;
   int          we_cnt[2] = '{default: 0};
   logic        we_prev[2] = '{default: 1'b0};
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      gpio_bus_master #(.READ_WAIT(g * 3)) u_dut (
         .clk         (clk),
         .arst_n      (arst_n),
         .cmd_valid   (cmd_valid[g]),
         .cmd_ready   (cmd_ready_w[g]),
         .cmd_op      (cmd_op[g]),
         .cmd_addr    (cmd_addr[g]),
         .cmd_data    (cmd_data[g]),
         .rsp_valid   (rsp_valid_w[g]),
         .rsp_ready   (rsp_ready[g]),
         .rsp_data    (rsp_data_w[g]),
         .rsp_err     (rsp_err_w[g]),
         .gpio_addr   (gaddr[g]),
         .gpio_i_data (gwdata[g]),
         .we          (we_w[g]),
         .gpio_o_data (grdata[g])
      );
      assign grdata[g] = gaddr[g] == 32'd128 ? p_ddr[g] :
                         gaddr[g] == 32'd129 ? ((p_ddr[g] & p_port[g]) | (~p_ddr[g] & io)) :
                         gaddr[g] == 32'd130 ? p_port[g] : 32'd0;
      // the peripheral clears DDR and PORT on a write to any other address
      always @(posedge clk) if (we_w[g]) begin
         if (gaddr[g] == 32'd128) p_ddr[g] <= gwdata[g];
         else if (gaddr[g] == 32'd130) p_port[g] <= gwdata[g];
         else begin
            p_ddr[g]  <= '0;
            p_port[g] <= '0;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void model(input int d, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] data, output logic err, output logic [31:0] v);
      logic [31:0] old;
      err = op > 3'd4 || !(addr == 32'd128 || addr == 32'd129 || addr == 32'd130) ||
            (addr == 32'd129 && op != 3'd0);
      v = '0;
      if (err) return;
      old = addr == 32'd128 ? m_ddr[d] : addr == 32'd130 ? m_port[d] :
            ((m_ddr[d] & m_port[d]) | (~m_ddr[d] & io));
      case (op)
         3'd0:    v = old;
         3'd1:    v = data;
         3'd2:    v = old | data;
         3'd3:    v = old & ~data;
         default: v = old ^ data;
      endcase
      if (op != 3'd0) begin
         if (addr == 32'd128) m_ddr[d] = v;
         else m_port[d] = v;
      end
   endfunction

   always @(negedge clk) if (arst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (we_w[d]) begin
            we_cnt[d]++;
            chk("we_addr_mapped", gaddr[d] == 32'd128 || gaddr[d] == 32'd130, 1);
            chk("we_single_cycle", we_prev[d], 0);
         end
         we_prev[d] = we_w[d];
         if (rsp_valid_w[d] && rsp_ready[d]) begin
            cmp_n = d == 0 ? q0.size() : q1.size();
            chk("rsp_expected", cmp_n != 0, 1);
            if (cmp_n != 0) begin
               cmp_e = d == 0 ? q0.pop_front() : q1.pop_front();
               chk("rsp_err_model", rsp_err_w[d], cmp_e[32]);
               chk("rsp_data_model", rsp_data_w[d], cmp_e[31:0]);
            end
         end
      end
   end

   // called and returning at posedge+1; hold leaves the response un-acknowledged
   task automatic issue(input int d, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input bit hold,
                        output logic [31:0] rdata, output logic err, output int lat);
      int n;
      logic e;
      logic [31:0] v;
      n = 0;
      while (!cmd_ready_w[d] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("cmd_ready_wait", n < 50, 1);
      model(d, op, addr, data, e, v);
      if (d == 0) q0.push_back({e, v});
      else q1.push_back({e, v});
      cmd_op[d] = op;
      cmd_addr[d] = addr;
      cmd_data[d] = data;
      cmd_valid[d] = 1'b1;
      @(posedge clk); #1;
      cmd_valid[d] = 1'b0;
      lat = 1;
      while (!rsp_valid_w[d] && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = rsp_data_w[d];
      err = rsp_err_w[d];
      if (!hold) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] r;
      logic e;
      int l;
      int wc;
      int n;
      for (int d = 0; d < 2; d++) begin
         cmd_valid[d] = 1'b0;
         rsp_ready[d] = 1'b1;
         cmd_op[d] = '0;
         cmd_addr[d] = '0;
         cmd_data[d] = '0;
      end
      #3;
      chk("rst_rsp_valid", rsp_valid_w[0], 0);
      chk("rst_rsp_err", rsp_err_w[0], 0);
      chk("rst_rsp_data", rsp_data_w[0], 0);
      chk("rst_gpio_addr", gaddr[0], 0);
      chk("rst_gpio_i_data", gwdata[0], 0);
      chk("rst_we", we_w[0], 0);
      @(posedge clk); #1;
      arst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_cmd_ready", cmd_ready_w[0], 1);

      wc = we_cnt[0];
      issue(0, 3'd1, 32'd128, 32'h0000_00FF, 0, r, e, l);
      chk("wr_ddr_lat", l, 2);
      chk("wr_ddr_data", r, 32'h0000_00FF);
      chk("wr_ddr_err", e, 0);
      chk("wr_ddr_we_count", we_cnt[0] - wc, 1);
      wc = we_cnt[0];
      issue(0, 3'd0, 32'd128, 32'h0, 0, r, e, l);
      chk("rd_ddr_lat", l, 2);
      chk("rd_ddr_data", r, 32'h0000_00FF);
      chk("rd_ddr_err", e, 0);
      chk("rd_ddr_we_count", we_cnt[0] - wc, 0);

      issue(0, 3'd1, 32'd130, 32'h0000_00F0, 0, r, e, l);
      wc = we_cnt[0];
      issue(0, 3'd2, 32'd130, 32'h0000_000F, 0, r, e, l);
      chk("set_lat", l, 3);
      chk("set_data", r, 32'h0000_00FF);
      chk("set_port", p_port[0], 32'h0000_00FF);
      chk("set_we_count", we_cnt[0] - wc, 1);
      issue(0, 3'd3, 32'd130, 32'h0000_0030, 0, r, e, l);
      chk("clr_lat", l, 3);
      chk("clr_data", r, 32'h0000_00CF);
      issue(0, 3'd4, 32'd130, 32'hFFFF_FFFF, 0, r, e, l);
      chk("tgl_lat", l, 3);
      chk("tgl_data", r, 32'hFFFF_FF30);
      chk("tgl_port", p_port[0], 32'hFFFF_FF30);

      issue(0, 3'd1, 32'd128, 32'h0, 0, r, e, l);
      io = 32'hA5A5_5A5A;
      issue(0, 3'd0, 32'd129, 32'h0, 0, r, e, l);
      chk("pin_lat", l, 2);
      chk("pin_data", r, 32'hA5A5_5A5A);
      issue(1, 3'd0, 32'd129, 32'h0, 0, r, e, l);
      chk("pin_wait3_lat", l, 5);
      chk("pin_wait3_data", r, 32'hA5A5_5A5A);
      issue(1, 3'd2, 32'd130, 32'h0000_0101, 0, r, e, l);
      chk("set_wait3_lat", l, 6);
      chk("set_wait3_data", r, 32'h0000_0101);

      wc = we_cnt[0];
      issue(0, 3'd1, 32'd129, 32'h1234_5678, 0, r, e, l);
      chk("wr_pin_err", e, 1);
      chk("wr_pin_data", r, 0);
      chk("wr_pin_lat", l, 1);
      issue(0, 3'd0, 32'd131, 32'h0, 0, r, e, l);
      chk("rd_131_err", e, 1);
      chk("rd_131_data", r, 0);
      issue(0, 3'd7, 32'd128, 32'hFFFF_FFFF, 0, r, e, l);
      chk("op7_err", e, 1);
      chk("op7_data", r, 0);
      chk("err_we_count", we_cnt[0] - wc, 0);
      chk("err_ddr_kept", p_ddr[0], 32'h0);
      chk("err_port_kept", p_port[0], 32'hFFFF_FF30);

      rsp_ready[0] = 1'b0;
      issue(0, 3'd0, 32'd130, 32'h0, 1, r, e, l);
      chk("bp_lat", l, 2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid_w[0], 1);
         chk("bp_rsp_data", rsp_data_w[0], 32'hFFFF_FF30);
         chk("bp_cmd_ready", cmd_ready_w[0], 0);
         chk("bp_we", we_w[0], 0);
      end
      @(posedge clk); #1;
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_cmd_ready", cmd_ready_w[0], 1);
      chk("bp_idle_rsp_valid", rsp_valid_w[0], 0);

      cmd_op[0] = 3'd2;
      cmd_addr[0] = 32'd130;
      cmd_data[0] = 32'h0000_000F;
      cmd_valid[0] = 1'b1;
      @(posedge clk); #1;
      cmd_valid[0] = 1'b0;
      n = 0;
      while (!we_w[0] && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("arst_we_reached", we_w[0], 1);
      arst_n = 1'b0;
      #1;
      chk("arst_we_drop", we_w[0], 0);
      chk("arst_rsp_valid", rsp_valid_w[0], 0);
      @(posedge clk); @(posedge clk); #2;
      arst_n = 1'b1;
      @(posedge clk); #1;
      chk("arst_cmd_ready", cmd_ready_w[0], 1);
      chk("arst_rsp_valid_after", rsp_valid_w[0], 0);
      chk("arst_port_kept", p_port[0], 32'hFFFF_FF30);
      issue(0, 3'd0, 32'd130, 32'h0, 0, r, e, l);
      chk("arst_rd_port", r, 32'hFFFF_FF30);
      chk("queues_drained", q0.size() + q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
